sdram_rdcheck: RTL and testbench

- Read-back counterpart to the SDRAM write-side data generator.
- After the system signals write complete, it reads back the same address range in 8-word bursts and drains the SDRAM read FIFO.
- It compares every word against the pattern the writer used, then reports a pass/fail verdict, an error count and the address of the first mismatch.
- It sits between the SDRAM controller's read-request/ack interface and the read-buffer FIFO (rdFIFO), on the 100 MHz system clock.

---
 rtl/sdram_pkg.sv | 24 ++
 rtl/sdram_rdcmp.sv | 43 ++++
 rtl/sdram_rdcheck.sv | 117 +++++++++++
 tb/tb_sdram_rdcheck.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_pkg.sv
// Shared types and constants for the SDRAM read-back checker.
// Burst geometry is fixed: moni_addr is {burst address, 3'b0}.
package sdram_pkg;

   localparam int unsigned BURST_LEN = 8;
   localparam int unsigned BEAT_W    = 3;
   localparam int unsigned ADDR_W    = 19;
   localparam int unsigned MADDR_W   = 22;

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      WAIT_ACK,
      DRAIN,
      LAST,
      DONE
   } rd_state_t;

   // Word n of the written pattern is base+n, wrapping at 16 bits.
   function automatic logic [15:0] exp_word(input logic [15:0] base, input logic [15:0] idx);
      return base + idx;
   endfunction

endpackage

// File: rtl/sdram_rdcmp.sv
// Read-word comparator: mismatch counting (saturating), first-error capture
// and the final pass verdict.
module sdram_rdcmp
   import sdram_pkg::*;
#(
   parameter logic [15:0] PAT_BASE = 16'h6211
) (
   input  logic               clk_100m,
   input  logic               rst,
   input  logic               rd_valid,
   input  logic [15:0]        rd_data,
   input  logic [15:0]        word_idx,
   input  logic [ADDR_W-1:0]  addr,
   input  logic               fin,
   input  logic               timeout_err,
   output logic [7:0]         err_cnt,
   output logic [MADDR_W-1:0] first_err_addr,
   output logic               chk_pass
);

   logic mismatch;

   assign mismatch = rd_valid && (rd_data != exp_word(PAT_BASE, word_idx));

   always_ff @(posedge clk_100m or posedge rst) begin
      if (rst) begin
         err_cnt        <= '0;
         first_err_addr <= '0;
         chk_pass       <= 1'b0;
      end else begin
         if (mismatch) begin
            if (err_cnt != 8'hFF)
               err_cnt <= err_cnt + 8'd1;
            // Beat is the low bits of the global index since bursts start on multiples of 8.
            if (err_cnt == '0)
               first_err_addr <= {addr, word_idx[BEAT_W-1:0]};
         end
         if (fin)
            chk_pass <= (err_cnt == '0) && !timeout_err;
      end
   end

endmodule

// File: rtl/sdram_rdcheck.sv
// SDRAM read-back checker: after the write phase, reads bursts 0..ADDR_END
// through the controller's req/ack handshake and the rdFIFO, and verifies them.
module sdram_rdcheck
   import sdram_pkg::*;
#(
   parameter logic [ADDR_W-1:0] ADDR_END    = 19'h00003,
   parameter logic [15:0]       PAT_BASE    = 16'h6211,
   parameter logic [15:0]       ACK_TIMEOUT = 16'd4095
) (
   input  logic               clk_100m,
   input  logic               rst,
   input  logic               syswr_done,
   input  logic               sdram_rd_ack,
   input  logic [15:0]        rdf_dout,
   output logic               sys_rd_req,
   output logic [MADDR_W-1:0] moni_addr,
   output logic               rdf_rdreq,
   output logic [15:0]        rd_data,
   output logic               rd_valid,
   output logic [7:0]         err_cnt,
   output logic [MADDR_W-1:0] first_err_addr,
   output logic               timeout_err,
   output logic               sysrd_done,
   output logic               chk_pass
);

   rd_state_t         state, state_nxt;
   logic              ackr1, ackr2, ack_fall, tmo_hit;
   logic [ADDR_W-1:0] addr;
   logic [BEAT_W-1:0] beat;
   logic [15:0]       tmo_cnt, widx;

   assign ack_fall  = ~ackr1 & ackr2;
   assign tmo_hit   = (tmo_cnt == ACK_TIMEOUT);
   assign moni_addr = {addr, {BEAT_W{1'b0}}};
   assign rd_data   = rd_valid ? rdf_dout : '0;

   always_ff @(posedge clk_100m or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // REQ accepts the synchronised ack level, so an ack already high on entry counts as the rise.
   always_comb begin
      state_nxt  = state;
      sys_rd_req = 1'b0;
      rdf_rdreq  = 1'b0;
      case (state)
         IDLE:     if (syswr_done) state_nxt = REQ;
         REQ: begin
            sys_rd_req = 1'b1;
            if (tmo_hit)    state_nxt = DONE;
            else if (ackr1) state_nxt = WAIT_ACK;
         end
         WAIT_ACK: begin
            if (tmo_hit)       state_nxt = DONE;
            else if (ack_fall) state_nxt = DRAIN;
         end
         DRAIN: begin
            rdf_rdreq = 1'b1;
            if (beat == BEAT_W'(BURST_LEN - 1)) state_nxt = LAST;
         end
         LAST:     state_nxt = (addr == ADDR_END) ? DONE : REQ;
         DONE:     state_nxt = DONE;
         default:  state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_100m or posedge rst) begin
      if (rst) begin
         ackr1       <= 1'b0;
         ackr2       <= 1'b0;
         addr        <= '0;
         beat        <= '0;
         tmo_cnt     <= '0;
         widx        <= '0;
         rd_valid    <= 1'b0;
         timeout_err <= 1'b0;
         sysrd_done  <= 1'b0;
      end else begin
         ackr1    <= sdram_rd_ack;
         ackr2    <= ackr1;
         rd_valid <= rdf_rdreq;
         if (rd_valid)
            widx <= widx + 16'd1;
         if ((state_nxt == REQ) && (state != REQ))
            tmo_cnt <= '0;
         else if ((state == REQ) || (state == WAIT_ACK))
            tmo_cnt <= tmo_cnt + 16'd1;
         if (state == DRAIN)
            beat <= beat + BEAT_W'(1);
         if ((state == LAST) && (addr != ADDR_END))
            addr <= addr + ADDR_W'(1);
         if (((state == REQ) || (state == WAIT_ACK)) && tmo_hit)
            timeout_err <= 1'b1;
         if (state == DONE)
            sysrd_done <= 1'b1;
      end
   end

   sdram_rdcmp #(
      .PAT_BASE (PAT_BASE)
   ) u_rdcmp (
      .clk_100m       (clk_100m),
      .rst            (rst),
      .rd_valid       (rd_valid),
      .rd_data        (rd_data),
      .word_idx       (widx),
      .addr           (addr),
      .fin            (state == DONE),
      .timeout_err    (timeout_err),
      .err_cnt        (err_cnt),
      .first_err_addr (first_err_addr),
      .chk_pass       (chk_pass)
   );

endmodule

// File: tb/tb_sdram_rdcheck.sv
// Bench for sdram_rdcheck: a controller/rdFIFO model feeds a 4-burst and a 41-burst
// instance; verdicts are compared against a per-word corruption map.
module tb_sdram_rdcheck;

   localparam logic [15:0] PAT        = 16'h6211;
   localparam int          TMO_CYCLES = 4096;
   localparam int          WORDS_A    = 32;
   localparam int          WORDS_B    = 328;

   logic        clk_100m;
   logic        rst_a, rst_b, syswr_done;
   logic        ack_pulse, pre_ack_hold, no_ack;
   logic        sdram_rd_ack;
   logic [15:0] rdf_dout;
   logic [15:0] mask [512];
   int          run_id;
   int          total, bad;
   bit          sel;

   logic        a_req, a_rdreq, a_rvalid, a_tmo, a_done, a_pass;
   logic [21:0] a_maddr, a_ferr;
   logic [15:0] a_rdata;
   logic [7:0]  a_err;
   logic        b_req, b_rdreq, b_rvalid, b_tmo, b_done, b_pass;
   logic [21:0] b_maddr, b_ferr;
   logic [15:0] b_rdata;
   logic [7:0]  b_err;

   initial clk_100m = 1'b0;
   always #5 clk_100m = ~clk_100m;

   assign sdram_rd_ack = pre_ack_hold | ack_pulse;

   sdram_rdcheck u_dut (
      .clk_100m (clk_100m), .rst (rst_a), .syswr_done (syswr_done),
      .sdram_rd_ack (sdram_rd_ack), .rdf_dout (rdf_dout),
      .sys_rd_req (a_req), .moni_addr (a_maddr), .rdf_rdreq (a_rdreq),
      .rd_data (a_rdata), .rd_valid (a_rvalid), .err_cnt (a_err),
      .first_err_addr (a_ferr), .timeout_err (a_tmo), .sysrd_done (a_done),
      .chk_pass (a_pass)
   );

   sdram_rdcheck #(.ADDR_END (19'd40)) u_big (
      .clk_100m (clk_100m), .rst (rst_b), .syswr_done (syswr_done),
      .sdram_rd_ack (sdram_rd_ack), .rdf_dout (rdf_dout),
      .sys_rd_req (b_req), .moni_addr (b_maddr), .rdf_rdreq (b_rdreq),
      .rd_data (b_rdata), .rd_valid (b_rvalid), .err_cnt (b_err),
      .first_err_addr (b_ferr), .timeout_err (b_tmo), .sysrd_done (b_done),
      .chk_pass (b_pass)
   );

   logic [73:0] outs_a, outs_b;
   assign outs_a = {a_req, a_maddr, a_rdreq, a_rdata, a_rvalid, a_err, a_ferr, a_tmo, a_done, a_pass};
   assign outs_b = {b_req, b_maddr, b_rdreq, b_rdata, b_rvalid, b_err, b_ferr, b_tmo, b_done, b_pass};

   logic        req_any, rdreq_any, rvalid_any;
   logic [21:0] moni_any;
   assign req_any    = a_req | b_req;
   assign rdreq_any  = a_rdreq | b_rdreq;
   assign rvalid_any = a_rvalid | b_rvalid;
   assign moni_any   = a_maddr | b_maddr;

   logic        o_req, o_tmo, o_done, o_pass;
   logic [7:0]  o_err;
   logic [21:0] o_ferr;
   assign o_req  = sel ? b_req  : a_req;
   assign o_tmo  = sel ? b_tmo  : a_tmo;
   assign o_done = sel ? b_done : a_done;
   assign o_pass = sel ? b_pass : a_pass;
   assign o_err  = sel ? b_err  : a_err;
   assign o_ferr = sel ? b_ferr : a_ferr;

   // Controller model: acks a request after a random delay and holds ack a random time.
   initial begin
      ack_pulse = 1'b0;
      forever begin
         @(negedge clk_100m);
         if (req_any && !pre_ack_hold && !no_ack) begin
            repeat ($urandom_range(0, 3)) @(negedge clk_100m);
            ack_pulse = 1'b1;
            repeat ($urandom_range(1, 10)) @(negedge clk_100m);
            ack_pulse = 1'b0;
         end
      end
   end

   // rdFIFO model: word n of the run is PAT+n xor its corruption mask, one cycle after rdreq.
   int d_seen, d_idx;
   initial begin
      rdf_dout = '0;
      d_seen   = 0;
      d_idx    = 0;
      forever begin
         @(negedge clk_100m);
         if (run_id != d_seen) begin
            d_seen = run_id;
            d_idx  = 0;
         end
         if (rdreq_any) begin
            @(posedge clk_100m);
            #1;
            rdf_dout = (PAT + 16'(d_idx)) ^ mask[d_idx % 512];
            d_idx++;
         end
      end
   end

   // Observer: request addresses, rdreq run lengths, request cycles and word strobes.
   int req_q [$];
   int len_q [$];
   int s_seen, cur_len, req_cycles, words;
   bit prev_req;
   initial begin
      s_seen = 0; cur_len = 0; req_cycles = 0; words = 0; prev_req = 0;
      forever begin
         @(negedge clk_100m);
         if (run_id != s_seen) begin
            s_seen = run_id;
            req_q.delete();
            len_q.delete();
            cur_len = 0; req_cycles = 0; words = 0; prev_req = 0;
         end
         if (req_any) begin
            req_cycles++;
            if (!prev_req) req_q.push_back(int'(moni_any));
         end
         prev_req = req_any;
         if (rdreq_any) cur_len++;
         else if (cur_len != 0) begin
            len_q.push_back(cur_len);
            cur_len = 0;
         end
         if (rvalid_any) words++;
      end
   end

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic start(input bit s);
      sel = s;
      rst_a = 1'b1; rst_b = 1'b1; syswr_done = 1'b0;
      repeat (3) @(negedge clk_100m);
      run_id++;
      if (s) rst_b = 1'b0; else rst_a = 1'b0;
      repeat (2) @(negedge clk_100m);
      syswr_done = 1'b1;
      repeat (3) @(negedge clk_100m);
      syswr_done = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int budget);
      for (int i = 0; i < budget && !o_done; i++) @(negedge clk_100m);
      chk({tag, "/done_in_time"}, o_done, 1'b1);
      repeat (10) @(negedge clk_100m);
   endtask

   // Reference verdict straight from the corruption map over the words read.
   task automatic check_run(input string tag, input int nwords);
      int  cnt, e_first;
      bit  found;
      cnt = 0; e_first = 0; found = 0;
      for (int i = 0; i < nwords; i++)
         if (mask[i] != 16'h0000) begin
            cnt++;
            if (!found) begin found = 1; e_first = i; end
         end
      chk({tag, "/err_cnt"}, o_err, (cnt > 255) ? 255 : cnt);
      chk({tag, "/first_err"}, o_ferr, e_first);
      chk({tag, "/pass"}, o_pass, cnt == 0);
      chk({tag, "/timeout"}, o_tmo, 1'b0);
      chk({tag, "/req_idle"}, o_req, 1'b0);
      chk({tag, "/words"}, words, nwords);
      chk({tag, "/n_req"}, req_q.size(), nwords / 8);
      for (int i = 0; i < req_q.size(); i++) chk({tag, "/req_addr"}, req_q[i], i * 8);
      chk({tag, "/n_burst"}, len_q.size(), nwords / 8);
      for (int i = 0; i < len_q.size(); i++) chk({tag, "/burst_len"}, len_q[i], 8);
   endtask

   task automatic clear_mask();
      for (int i = 0; i < 512; i++) mask[i] = 16'h0000;
   endtask

   initial begin
      total = 0; bad = 0; run_id = 0; sel = 0;
      rst_a = 1'b1; rst_b = 1'b1; syswr_done = 1'b0;
      pre_ack_hold = 1'b0; no_ack = 1'b0;
      clear_mask();
      repeat (3) @(negedge clk_100m);
      chk("reset_outs_a", outs_a, '0);
      chk("reset_outs_b", outs_b, '0);

      // Clean read-back of 4 bursts; syswr_done drops after the start.
      start(0);
      wait_done("clean", 3000);
      check_run("clean", WORDS_A);

      // Single bad word: burst 2, beat 3 reads 0x0000.
      clear_mask();
      mask[19] = PAT + 16'd19;
      start(0);
      wait_done("one_err", 3000);
      check_run("one_err", WORDS_A);

      // Random corruption maps.
      for (int r = 0; r < 3; r++) begin
         clear_mask();
         for (int i = 0; i < WORDS_A; i++)
            if ($urandom_range(0, 3) == 0) mask[i] = 16'($urandom_range(1, 65535));
         start(0);
         wait_done("random", 3000);
         check_run("random", WORDS_A);
      end

      // Controller never acks.
      clear_mask();
      no_ack = 1'b1;
      start(0);
      wait_done("timeout", TMO_CYCLES + 500);
      chk("timeout/req_cycles", req_cycles, TMO_CYCLES);
      chk("timeout/req_low", o_req, 1'b0);
      chk("timeout/flag", o_tmo, 1'b1);
      chk("timeout/pass", o_pass, 1'b0);
      chk("timeout/err_cnt", o_err, 8'd0);
      chk("timeout/words", words, 0);
      no_ack = 1'b0;

      // Reset during beat 4 of the first drain, then a full clean restart.
      start(0);
      for (int i = 0; i < 500 && !a_rdreq; i++) @(negedge clk_100m);
      chk("midrst/drain_seen", a_rdreq, 1'b1);
      repeat (4) @(negedge clk_100m);
      chk("midrst/beat4_rdreq", a_rdreq, 1'b1);
      #1 rst_a = 1'b1;
      #1 chk("midrst/async_outs", outs_a, '0);
      start(0);
      wait_done("restart", 3000);
      check_run("restart", WORDS_A);

      // Ack already high before the first request.
      pre_ack_hold = 1'b1;
      repeat (3) @(negedge clk_100m);
      start(0);
      repeat (10) @(negedge clk_100m);
      pre_ack_hold = 1'b0;
      wait_done("pre_ack", 3000);
      check_run("pre_ack", WORDS_A);

      // 41 bursts, every word wrong: counter saturates.
      for (int i = 0; i < 512; i++) mask[i] = 16'($urandom_range(1, 65535));
      start(1);
      wait_done("saturate", 20000);
      check_run("saturate", WORDS_B);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
